// File: rtl/led_matrix_scanner.sv
// Row-scanned 8x8 LED matrix driver with a tear-free frame shadow and per-row anti-ghost blanking.
// Optional feature macro LED_SCAN_DIM_EN: adds a 4-bit brightness input gating the lit window via PWM.
module led_matrix_scanner #(
  parameter int unsigned ROW_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] grid_in,
  input  logic        reload,
  input  logic        blank_req,
`ifdef LED_SCAN_DIM_EN
  input  logic [3:0]  brightness,
`endif
  output logic [7:0]  row_sel,
  output logic [7:0]  col_out,
  output logic        frame_start
);

  localparam int unsigned CW = $clog2(ROW_DIV);
  localparam logic [CW-1:0] CNT_LAST    = CW'(ROW_DIV - 1);
  localparam logic [CW-1:0] BLANK_START = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    row_q, row_d;
  logic [63:0]   shadow_q, shadow_d;
  logic [7:0]    row_sel_q, row_sel_d;
  logic [7:0]    col_out_q, col_out_d;
  logic          frame_start_q, frame_start_d;
  logic          lit;

`ifdef LED_SCAN_DIM_EN
  logic [3:0]    pwm_q, pwm_d;
`endif

  always_comb begin
    cnt_d         = cnt_q;
    row_d         = row_q;
    shadow_d      = shadow_q;
    frame_start_d = 1'b0;
    if (reload) begin
      cnt_d         = '0;
      row_d         = 3'd0;
      shadow_d      = grid_in;
      frame_start_d = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      row_d = row_q + 3'd1;
      if (row_q == 3'd7) begin
        shadow_d      = grid_in;
        frame_start_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are computed from next-state values so row_sel and col_out switch together.
  always_comb begin
`ifdef LED_SCAN_DIM_EN
    pwm_d = pwm_q + 4'd1;
`endif
    lit = (cnt_d >= BLANK_START) && !blank_req;
`ifdef LED_SCAN_DIM_EN
    lit = lit && (pwm_d < brightness);
`endif
    row_sel_d = 8'h01 << row_d;
    col_out_d = lit ? shadow_d[{row_d, 3'b000} +: 8] : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      row_q         <= 3'd0;
      shadow_q      <= '0;
      row_sel_q     <= 8'h01;
      col_out_q     <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      shadow_q      <= shadow_d;
      row_sel_q     <= row_sel_d;
      col_out_q     <= col_out_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef LED_SCAN_DIM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_q <= 4'd0;
    else     pwm_q <= pwm_d;
  end
`endif

  assign row_sel     = row_sel_q;
  assign col_out     = col_out_q;
  assign frame_start = frame_start_q;

endmodule
